// File: rtl/alu_dot_issuer.sv
// ---------------------------------------------------------------------------
// alu_dot_issuer
//
// Drives the MAC path of riscv_alu to compute a dot product. A command carries
// the number of (a,b) pairs. The issuer first sends one ADD 0,0 so the ALU
// clears its accumulator. It then forwards each operand pair as a MAC. The ALU
// result from the last MAC is the complete sum, and the issuer holds it until
// the consumer takes it.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_len = number of pairs
//   in_valid/in_ready        operand pair stream (in_a, in_b)
//   alu_valid/alu_a/alu_b/alu_op   issue port into the ALU
//   alu_result               ALU result, valid in the same cycle as the issue
//   res_valid/res_ready      result handshake; res_data = sum mod 2^WIDTH
//   busy                     high whenever this block owns the ALU
// ---------------------------------------------------------------------------
module alu_dot_issuer #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             alu_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MAC = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        res_data_d  = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_len;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // An empty command skips RUN and reports a zero sum.
                if (remaining_q == '0) begin
                    res_data_d = '0;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    // The MAC issued on the final beat already includes every
                    // earlier product, so its result is the finished sum.
                    if (remaining_q == LEN_W'(1)) begin
                        res_data_d = alu_result;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            res_data_q  <= res_data_d;
        end
    end

    // Handshake and status outputs are decoded directly from the state flops.
    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_data  = res_data_q;

    // ALU issue port. In RUN the operand stream passes straight through, so a
    // stalled beat produces no issue and leaves the accumulator untouched.
    always_comb begin
        alu_valid = 1'b0;
        alu_op    = OP_ADD;
        alu_a     = '0;
        alu_b     = '0;
        case (state_q)
            S_CLEAR: begin
                alu_valid = 1'b1;
            end
            S_RUN: begin
                alu_valid = in_valid;
                alu_op    = OP_MAC;
                alu_a     = in_a;
                alu_b     = in_b;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_dot_issuer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_dot_issuer. It contains a behavioural ALU with an
// accumulator that answers within the same cycle. Expected sums are computed
// directly as sum(a*b) mod 2^32.
// ---------------------------------------------------------------------------
module tb_alu_dot_issuer;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MAC = 4'b1011;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             alu_valid;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_dot_issuer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_valid  (alu_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    // Behavioural ALU. ADD writes a+b into the accumulator, and MAC adds a*b
    // to it. The reset does not touch the accumulator.
    logic [WIDTH-1:0] acc = 32'hDEAD_BEEF;
    int n_add = 0;
    int n_mac = 0;

    always_comb begin
        if (alu_op == OP_MAC) alu_result = alu_a * alu_b + acc;
        else                  alu_result = alu_a + alu_b;
    end

    always @(posedge clk) begin
        if (alu_valid) begin
            acc <= alu_result;
            if (alu_op == OP_ADD) n_add++;
            else if (alu_op == OP_MAC) n_mac++;
        end
    end

    // Per-command stimulus: operand pairs and the idle cycles placed before
    // each beat.
    logic [WIDTH-1:0] va [16];
    logic [WIDTH-1:0] vb [16];
    int               vgap [16];

    // Observations recorded by do_cmd
    int               obs_res_cycle;
    logic [WIDTH-1:0] obs_res_data;
    int               obs_ready_cycle;
    logic             obs_ready_after;
    logic             obs_busy_after;
    int               obs_issue_err;
    int               obs_hold_err;
    logic             obs_in_ready_seen;
    logic             obs_timeout;
    int               obs_adds;
    int               obs_macs;

    function automatic logic [WIDTH-1:0] dot_ref(input int len);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < len; i++) s = s + va[i] * vb[i];
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
    endtask

    // Runs one command. Cycle numbering: cycle 0 is the handshake cycle and
    // cycle k is the cycle k edges later. The task records when res_valid
    // rises, whether each cycle's ALU issue matched what was offered, and
    // whether the result stayed stable while held for 'hold' cycles.
    // If pulse is set, cmd_valid toggles during the hold.
    task automatic do_cmd(input int len, input int hold, input bit pulse);
        int idx;
        int gap_left;
        int cyc;
        int add0;
        int mac0;
        bit offered;
        logic [WIDTH-1:0] held;
        add0 = n_add;
        mac0 = n_mac;
        obs_issue_err     = 0;
        obs_hold_err      = 0;
        obs_in_ready_seen = 1'b0;
        obs_timeout       = 1'b1;
        obs_res_cycle     = -1;
        obs_res_data      = '0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        step();
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cyc      = 1;
        idx      = 0;
        gap_left = vgap[0];
        for (int budget = 0; budget < 400; budget++) begin
            if (res_valid) begin
                obs_timeout = 1'b0;
                break;
            end
            if (in_ready) obs_in_ready_seen = 1'b1;
            offered = 1'b0;
            in_valid = 1'b0;
            if (in_ready && idx < len) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    in_valid = 1'b1;
                    in_a     = va[idx];
                    in_b     = vb[idx];
                    offered  = 1'b1;
                    idx++;
                    if (idx < len) gap_left = vgap[idx];
                end
            end
            #1;
            // Cycle 1 must carry the clearing ADD 0,0. After that, exactly the
            // offered beats must appear as MACs with unchanged operands.
            if (cyc == 1) begin
                if (!(alu_valid === 1'b1 && alu_op === OP_ADD && alu_a === '0 && alu_b === '0))
                    obs_issue_err++;
            end else if (offered) begin
                if (!(alu_valid === 1'b1 && alu_op === OP_MAC && alu_a === in_a && alu_b === in_b))
                    obs_issue_err++;
            end else if (alu_valid !== 1'b0) begin
                obs_issue_err++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        obs_res_cycle = cyc;
        obs_res_data  = res_data;
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            cmd_valid = pulse ? ((h % 2) == 0) : 1'b0;
            cmd_len   = 16'd7;
            #1;
            if (res_valid !== 1'b1 || res_data !== held || cmd_ready !== 1'b0 || alu_valid !== 1'b0)
                obs_hold_err++;
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        cmd_len   = '0;
        res_ready = 1'b1;
        step();
        cyc++;
        res_ready = 1'b0;
        obs_ready_cycle = cyc;
        obs_ready_after = cmd_ready;
        obs_busy_after  = busy;
        obs_adds = n_add - add0;
        obs_macs = n_mac - mac0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (alu_valid !== 1'b0 || alu_op !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin
            n_err++; $display("FAIL reset_alu_port got=%b/%h/%h/%h exp=0", alu_valid, alu_op, alu_a, alu_b); end
        n_vec++; if (res_valid !== 1'b0 || res_data !== '0) begin
            n_err++; $display("FAIL reset_result got=%b/%h exp=0/0", res_valid, res_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        step();
        $display("test_reset: outputs at reset values checked");
    endtask

    task automatic test_back_to_back();
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
        for (int i = 0; i < 16; i++) vgap[i] = 0;
        do_cmd(3, 0, 1'b0);
        n_vec++; if (obs_timeout) begin n_err++; $display("FAIL b2b_timeout got=no res_valid exp=res_valid"); end
        n_vec++; if (obs_res_data !== 32'd68) begin n_err++; $display("FAIL b2b_data got=%0d exp=68", obs_res_data); end
        // With no stalls, res_valid appears in cycle N+2 after the handshake.
        n_vec++; if (obs_res_cycle != 5) begin n_err++; $display("FAIL b2b_latency got=%0d exp=5", obs_res_cycle); end
        n_vec++; if (obs_ready_cycle != 6 || obs_ready_after !== 1'b1) begin
            n_err++; $display("FAIL b2b_turnaround got=cyc%0d/ready%b exp=cyc6/ready1", obs_ready_cycle, obs_ready_after); end
        n_vec++; if (obs_adds != 1 || obs_macs != 3) begin
            n_err++; $display("FAIL b2b_issues got=add%0d/mac%0d exp=add1/mac3", obs_adds, obs_macs); end
        n_vec++; if (obs_issue_err != 0) begin n_err++; $display("FAIL b2b_issue_seq got=%0d bad cycles exp=0", obs_issue_err); end
        $display("test_back_to_back: res_data=%0d res_cycle=%0d", obs_res_data, obs_res_cycle);
    endtask

    task automatic test_stall();
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
        vgap[0] = 0; vgap[1] = 2; vgap[2] = 2;
        do_cmd(3, 0, 1'b0);
        n_vec++; if (obs_res_data !== 32'd68) begin n_err++; $display("FAIL stall_data got=%0d exp=68", obs_res_data); end
        n_vec++; if (obs_issue_err != 0) begin n_err++; $display("FAIL stall_issue_seq got=%0d bad cycles exp=0", obs_issue_err); end
        n_vec++; if (obs_res_cycle != 9) begin n_err++; $display("FAIL stall_latency got=%0d exp=9", obs_res_cycle); end
        n_vec++; if (obs_macs != 3) begin n_err++; $display("FAIL stall_macs got=%0d exp=3", obs_macs); end
        $display("test_stall: res_data=%0d res_cycle=%0d", obs_res_data, obs_res_cycle);
    endtask

    task automatic test_zero_len();
        do_cmd(0, 0, 1'b0);
        n_vec++; if (obs_res_data !== '0) begin n_err++; $display("FAIL zero_data got=%h exp=0", obs_res_data); end
        n_vec++; if (obs_res_cycle != 2) begin n_err++; $display("FAIL zero_latency got=%0d exp=2", obs_res_cycle); end
        n_vec++; if (obs_adds != 1 || obs_macs != 0) begin
            n_err++; $display("FAIL zero_issues got=add%0d/mac%0d exp=add1/mac0", obs_adds, obs_macs); end
        n_vec++; if (obs_in_ready_seen !== 1'b0) begin n_err++; $display("FAIL zero_in_ready got=1 exp=never"); end
        $display("test_zero_len: res_data=%0d res_cycle=%0d", obs_res_data, obs_res_cycle);
    endtask

    task automatic test_wrap();
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
        va[1] = 32'h8000_0000; vb[1] = 32'd2;
        vgap[0] = 0; vgap[1] = 0;
        do_cmd(2, 0, 1'b0);
        n_vec++; if (obs_res_data !== 32'h0000_0001) begin n_err++; $display("FAIL wrap_data got=%h exp=00000001", obs_res_data); end
        $display("test_wrap: res_data=%h", obs_res_data);
    endtask

    task automatic test_hold();
        va[0] = 9; vb[0] = 11; va[1] = 3; vb[1] = 4;
        vgap[0] = 0; vgap[1] = 1;
        do_cmd(2, 5, 1'b1);
        n_vec++; if (obs_res_data !== 32'd111) begin n_err++; $display("FAIL hold_data got=%0d exp=111", obs_res_data); end
        n_vec++; if (obs_hold_err != 0) begin n_err++; $display("FAIL hold_stable got=%0d bad cycles exp=0", obs_hold_err); end
        // A stray cmd_valid accepted during DONE would leave the block busy here.
        n_vec++; if (obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0) begin
            n_err++; $display("FAIL hold_release got=ready%b/busy%b exp=ready1/busy0", obs_ready_after, obs_busy_after); end
        va[0] = 5; vb[0] = 6; vgap[0] = 0;
        do_cmd(1, 0, 1'b0);
        n_vec++; if (obs_res_data !== 32'd30) begin n_err++; $display("FAIL hold_next_data got=%0d exp=30", obs_res_data); end
        $display("test_hold: held=111 next=%0d", obs_res_data);
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_len   = 16'd4;
        step();
        cmd_valid = 1'b0;
        step();                 // in RUN now
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd7;
        step();                 // one beat accepted
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        n_vec++; if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || alu_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs got=cr%b ir%b busy%b rv%b av%b exp=cr1 ir0 busy0 rv0 av0",
                              cmd_ready, in_ready, busy, res_valid, alu_valid); end
        rst = 1'b0;
        step();
        va[0] = 3; vb[0] = 3; vgap[0] = 0;
        do_cmd(1, 0, 1'b0);
        n_vec++; if (obs_res_data !== 32'd9) begin n_err++; $display("FAIL midrst_data got=%0d exp=9", obs_res_data); end
        $display("test_reset_mid: res_data=%0d", obs_res_data);
    endtask

    task automatic test_random();
        int len;
        logic [WIDTH-1:0] exp;
        for (int t = 0; t < 8; t++) begin
            len = int'($urandom_range(0, 8));
            for (int i = 0; i < 16; i++) begin
                va[i]   = $urandom;
                vb[i]   = $urandom;
                vgap[i] = int'($urandom_range(0, 2));
            end
            exp = dot_ref(len);
            do_cmd(len, int'($urandom_range(0, 3)), 1'b1);
            n_vec++; if (obs_res_data !== exp) begin
                n_err++; $display("FAIL rand%0d_data got=%h exp=%h", t, obs_res_data, exp); end
            n_vec++; if (obs_issue_err != 0 || obs_hold_err != 0 || obs_macs != len || obs_adds != 1) begin
                n_err++; $display("FAIL rand%0d_issues got=err%0d hold%0d mac%0d add%0d exp=0 0 %0d 1",
                                  t, obs_issue_err, obs_hold_err, obs_macs, obs_adds, len); end
            $display("test_random %0d: len=%0d res_data=%h", t, len, obs_res_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_stall();
        test_zero_len();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
